// File: rtl/hdp_pkg.sv
// hdp_pkg
// Shared definitions for the HDP data-memory arbiter.
//   AW / DW     : default data-memory word-address and data widths
//   arb_state_e : arbiter FSM states (ARB = normal round-robin, LOCK = debug owns memory)
//   rr_ptr_e    : round-robin pointer, names the requester that wins a tie
package hdp_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef enum logic {
    FAV_CORE = 1'b0,
    FAV_DBG  = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/hdp_dmem_arbiter_if.sv
// hdp_dmem_arbiter_if
// Bundles the three buses around the data-memory arbiter.
//   core  side : c_req, c_we, c_addr, c_wdata -> arbiter; c_gnt, c_rvalid, c_rdata, c_stall <- arbiter
//   debug side : d_req, d_we, d_lock, d_addr, d_wdata -> arbiter; d_gnt, d_rvalid, d_rdata <- arbiter
//   memory side: m_en, m_we, m_addr, m_wdata <- arbiter; m_rdata -> arbiter (one cycle after a read)
// Modport slave is the arbiter's view, master is the requester/memory environment's view.
interface hdp_dmem_arbiter_if #(
  parameter int AW = hdp_pkg::AW,
  parameter int DW = hdp_pkg::DW
);

  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          c_stall;

  logic          d_req;
  logic          d_we;
  logic          d_lock;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, c_stall,
    input  d_req, d_we, d_lock, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, c_stall,
    output d_req, d_we, d_lock, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/hdp_dmem_arbiter.sv
// hdp_dmem_arbiter
// Two-port arbiter in front of a single-port data memory: the CPU core and a debug
// port share it with round-robin fairness, and the debug port may lock the memory
// for up to MAX_LOCK consecutive cycles.
//   clk : sole clock
//   RN  : synchronous, active-high reset
//   bus : hdp_dmem_arbiter_if.slave -- core, debug and memory buses
module hdp_dmem_arbiter #(
  parameter int AW       = hdp_pkg::AW,
  parameter int DW       = hdp_pkg::DW,
  parameter int MAX_LOCK = 16
) (
  input logic               clk,
  input logic               RN,
  hdp_dmem_arbiter_if.slave bus
);

  import hdp_pkg::*;

  localparam int            CW      = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

  arb_state_e    state_q, state_d;
  rr_ptr_e       ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ign_q, ign_d;
  logic          c_win, d_win;
  logic          c_rv_q, d_rv_q;
  logic [DW-1:0] c_hold_q, d_hold_q;

  // Grant selection and FSM next state. ign_q is set only for the single cycle
  // after a lock expires, so a debug grant then cannot re-enter LOCK and a
  // waiting core request wins through the pointer forced to FAV_CORE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ign_d   = 1'b0;
    c_win   = 1'b0;
    d_win   = 1'b0;
    unique case (state_q)
      ARB: begin
        cnt_d = '0;
        if (bus.c_req && (!bus.d_req || ptr_q == FAV_CORE)) begin
          c_win = 1'b1;
        end else if (bus.d_req) begin
          d_win = 1'b1;
        end
        if (d_win && bus.d_lock && !ign_q) begin
          state_d = LOCK;
          cnt_d   = CNT_ONE;
        end
      end
      LOCK: begin
        d_win = bus.d_req;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_d >= CNT_MAX) begin
          state_d = ARB;
          cnt_d   = '0;
          ign_d   = 1'b1;
        end else if (!bus.d_lock) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
    // Nothing may be granted while reset is held.
    if (RN) begin
      c_win = 1'b0;
      d_win = 1'b0;
    end
    if (c_win) begin
      ptr_d = FAV_DBG;
    end else if (d_win) begin
      ptr_d = FAV_CORE;
    end
    if (ign_d) begin
      ptr_d = FAV_CORE;
    end
  end

  // Memory command routing: the winner's fields pass straight through, idle is all-zero.
  assign bus.c_gnt   = c_win;
  assign bus.d_gnt   = d_win;
  assign bus.c_stall = bus.c_req & ~c_win;
  assign bus.m_en    = c_win | d_win;
  assign bus.m_we    = (c_win & bus.c_we) | (d_win & bus.d_we);
  assign bus.m_addr  = c_win ? bus.c_addr  : (d_win ? bus.d_addr  : {AW{1'b0}});
  assign bus.m_wdata = c_win ? bus.c_wdata : (d_win ? bus.d_wdata : {DW{1'b0}});

  // Read return: memory data is forwarded in the rvalid cycle and captured so
  // rdata holds afterwards. Masking with RN keeps a read granted just before
  // reset from showing up while reset is asserted.
  assign bus.c_rvalid = c_rv_q & ~RN;
  assign bus.d_rvalid = d_rv_q & ~RN;
  assign bus.c_rdata  = RN ? '0 : (c_rv_q ? bus.m_rdata : c_hold_q);
  assign bus.d_rdata  = RN ? '0 : (d_rv_q ? bus.m_rdata : d_hold_q);

  // State, pointer, lock counter and read-return registers.
  always_ff @(posedge clk) begin
    if (RN) begin
      state_q  <= ARB;
      ptr_q    <= FAV_CORE;
      cnt_q    <= '0;
      ign_q    <= 1'b0;
      c_rv_q   <= 1'b0;
      d_rv_q   <= 1'b0;
      c_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ign_q   <= ign_d;
      c_rv_q  <= c_win & ~bus.c_we;
      d_rv_q  <= d_win & ~bus.d_we;
      if (c_rv_q) begin
        c_hold_q <= bus.m_rdata;
      end
      if (d_rv_q) begin
        d_hold_q <= bus.m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_hdp_dmem_arbiter.sv
// Testbench for hdp_dmem_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the arbitration rules and of
// the memory contents.
module tb_hdp_dmem_arbiter;

  localparam int AW       = hdp_pkg::AW;
  localparam int DW       = hdp_pkg::DW;
  localparam int MAX_LOCK = 16;

  logic clk;
  logic resetIn;
  logic initMem;

  hdp_dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  hdp_dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk (clk),
    .RN  (resetIn),
    .bus (bus.slave)
  );

  int checks;
  int errors;

  // Memory environment: single-port, read data one cycle after the read, noise otherwise.
  logic [DW-1:0] memArr [32];

  always @(posedge clk) begin
    if (initMem) begin
      for (int i = 0; i < 32; i++) begin
        memArr[i] <= (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
      end
    end else if (bus.m_en && bus.m_we) begin
      memArr[bus.m_addr] <= bus.m_wdata;
    end
    if (bus.m_en && !bus.m_we) begin
      bus.m_rdata <= memArr[bus.m_addr];
    end else begin
      bus.m_rdata <= $urandom;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: who owns memory, fairness history, expected memory image.
  bit            mInLock;
  int            mLockLen;
  bit            mIgnore;
  bit            mLastDbg;
  bit            pendC, pendD;
  logic [DW-1:0] pendCData, pendDData, holdC, holdD;
  logic [DW-1:0] refMem [32];

  logic          obsCgnt, obsDgnt, obsCstall, obsMen, obsCrvalid, obsDrvalid;
  logic [DW-1:0] obsCrdata, obsDrdata;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks every output against the model at the
  // falling edge, advances the model and returns just after the next rising edge.
  task automatic applyStimulus(input bit rn, input bit cReq, input bit cWe,
                               input logic [AW-1:0] cAddr, input logic [DW-1:0] cWdata,
                               input bit dReq, input bit dWe, input bit dLock,
                               input logic [AW-1:0] dAddr, input logic [DW-1:0] dWdata);
    bit            expC, expD, expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWd;
    resetIn     = rn;
    bus.c_req   = cReq;
    bus.c_we    = cWe;
    bus.c_addr  = cAddr;
    bus.c_wdata = cWdata;
    bus.d_req   = dReq;
    bus.d_we    = dWe;
    bus.d_lock  = dLock;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
    @(negedge clk);

    expC = 1'b0;
    expD = 1'b0;
    if (!rn) begin
      if (mInLock) begin
        expD = dReq;
      end else if (cReq && dReq) begin
        expC = mLastDbg;
        expD = !mLastDbg;
      end else begin
        expC = cReq;
        expD = dReq;
      end
    end
    expWe   = expC ? cWe    : (expD ? dWe    : 1'b0);
    expAddr = expC ? cAddr  : (expD ? dAddr  : '0);
    expWd   = expC ? cWdata : (expD ? dWdata : '0);

    obsCgnt    = bus.c_gnt;
    obsDgnt    = bus.d_gnt;
    obsCstall  = bus.c_stall;
    obsMen     = bus.m_en;
    obsCrvalid = bus.c_rvalid;
    obsDrvalid = bus.d_rvalid;
    obsCrdata  = bus.c_rdata;
    obsDrdata  = bus.d_rdata;

    checkOutput("c_gnt",    32'(obsCgnt),    32'(expC));
    checkOutput("d_gnt",    32'(obsDgnt),    32'(expD));
    checkOutput("c_stall",  32'(obsCstall),  32'(cReq && !expC));
    checkOutput("m_en",     32'(obsMen),     32'(expC || expD));
    checkOutput("m_we",     32'(bus.m_we),   32'(expWe));
    checkOutput("m_addr",   32'(bus.m_addr), 32'(expAddr));
    checkOutput("m_wdata",  bus.m_wdata,     expWd);
    checkOutput("c_rvalid", 32'(obsCrvalid), 32'(pendC && !rn));
    checkOutput("d_rvalid", 32'(obsDrvalid), 32'(pendD && !rn));
    checkOutput("c_rdata",  obsCrdata,       rn ? '0 : (pendC ? pendCData : holdC));
    checkOutput("d_rdata",  obsDrdata,       rn ? '0 : (pendD ? pendDData : holdD));

    if (rn) begin
      mInLock  = 1'b0;
      mLockLen = 0;
      mIgnore  = 1'b0;
      mLastDbg = 1'b1;
      pendC    = 1'b0;
      pendD    = 1'b0;
      holdC    = '0;
      holdD    = '0;
    end else begin
      if (pendC) holdC = pendCData;
      if (pendD) holdD = pendDData;
      pendC     = expC && !cWe;
      pendD     = expD && !dWe;
      pendCData = refMem[cAddr];
      pendDData = refMem[dAddr];
      if (expC && cWe) refMem[cAddr] = cWdata;
      if (expD && dWe) refMem[dAddr] = dWdata;
      if (expC) mLastDbg = 1'b0;
      if (expD) mLastDbg = 1'b1;
      if (mInLock) begin
        mLockLen++;
        if (mLockLen >= MAX_LOCK) begin
          mInLock  = 1'b0;
          mLastDbg = 1'b1;
          mIgnore  = 1'b1;
        end else if (!dLock) begin
          mInLock = 1'b0;
        end
      end else begin
        if (expD && dLock && !mIgnore) begin
          mInLock  = 1'b1;
          mLockLen = 1;
        end
        mIgnore = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int dGrants;
  bit sawCore;
  bit anyActivity;
  bit holdLock;
  bit patC [4];

  // Directed scenarios first, then randomized traffic.
  initial begin
    checks  = 0;
    errors  = 0;
    initMem = 1'b1;
    for (int i = 0; i < 32; i++) begin
      refMem[i] = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
    end
    mInLock = 0; mLockLen = 0; mIgnore = 0; mLastDbg = 1;
    pendC = 0; pendD = 0; pendCData = '0; pendDData = '0; holdC = '0; holdD = '0;
    resetIn = 1'b1;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_lock = 0; bus.d_addr = '0; bus.d_wdata = '0;
    @(posedge clk);
    #1;
    initMem = 1'b0;

    // Reset with requests pending: no grant, no memory activity.
    applyStimulus(1, 1, 1, 5'd7, 32'hDEAD_BEEF, 1, 0, 1, 5'd9, 32'h1);
    checkOutput("rst_c_gnt", 32'(obsCgnt), 32'd0);
    checkOutput("rst_d_gnt", 32'(obsDgnt), 32'd0);
    checkOutput("rst_m_en",  32'(obsMen),  32'd0);
    applyStimulus(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);

    // Idle for ten cycles.
    anyActivity = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
      anyActivity = anyActivity | obsMen | obsCgnt | obsDgnt | obsCrvalid | obsDrvalid;
    end
    checkOutput("idle_quiet", 32'(anyActivity), 32'd0);

    // Core write then read of address 3.
    applyStimulus(0, 1, 1, 5'd3, 32'h1234_5678, 0, 0, 0, '0, '0);
    checkOutput("cwr_gnt", 32'(obsCgnt), 32'd1);
    applyStimulus(0, 1, 0, 5'd3, '0, 0, 0, 0, '0, '0);
    checkOutput("crd_gnt", 32'(obsCgnt), 32'd1);
    applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    checkOutput("crd_rvalid", 32'(obsCrvalid), 32'd1);
    checkOutput("crd_rdata",  obsCrdata, 32'h1234_5678);
    applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    checkOutput("crd_rvalid_drop", 32'(obsCrvalid), 32'd0);
    checkOutput("crd_rdata_hold",  obsCrdata, 32'h1234_5678);

    // Both requesting from reset: C, D, C, D, stall only in debug cycles.
    applyStimulus(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    patC = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 5'd1, '0, 1, 0, 0, 5'd2, '0);
      checkOutput($sformatf("rr_c_gnt%0d", i), 32'(obsCgnt),   32'(patC[i]));
      checkOutput($sformatf("rr_d_gnt%0d", i), 32'(obsDgnt),   32'(!patC[i]));
      checkOutput($sformatf("rr_stall%0d", i), 32'(obsCstall), 32'(!patC[i]));
    end

    // Lock held continuously: MAX_LOCK debug grants, then core wins despite d_lock.
    applyStimulus(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    applyStimulus(0, 1, 0, 5'd4, '0, 1, 0, 1, 5'd5, '0);
    checkOutput("lock_first_core", 32'(obsCgnt), 32'd1);
    dGrants = 0;
    sawCore = 1'b0;
    for (int i = 0; i < 40 && !sawCore; i++) begin
      applyStimulus(0, 1, 0, 5'd4, '0, 1, 0, 1, 5'd5, '0);
      if (obsCgnt) sawCore = 1'b1;
      else if (obsDgnt) dGrants++;
    end
    checkOutput("lock_core_after_expiry", 32'(sawCore), 32'd1);
    checkOutput("lock_dbg_grants", 32'(dGrants), 32'(MAX_LOCK));

    // Lock released early: entry cycle plus three locked cycles, drop, then core.
    applyStimulus(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    applyStimulus(0, 1, 0, 5'd6, '0, 1, 1, 1, 5'd8, 32'h55);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 5'd6, '0, 1, 1, 1, 5'd8, 32'h60 + 32'(i));
      checkOutput($sformatf("early_dbg%0d", i), 32'(obsDgnt), 32'd1);
    end
    applyStimulus(0, 1, 0, 5'd6, '0, 1, 1, 0, 5'd8, 32'h77);
    applyStimulus(0, 1, 0, 5'd6, '0, 1, 1, 0, 5'd8, 32'h78);
    checkOutput("early_core_gnt", 32'(obsCgnt), 32'd1);

    // Debug read of address 31 followed by reset: no rvalid leaks through.
    applyStimulus(0, 0, 0, '0, '0, 1, 0, 0, 5'd31, '0);
    checkOutput("rd31_gnt", 32'(obsDgnt), 32'd1);
    applyStimulus(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    checkOutput("rd31_rst_rvalid", 32'(obsDrvalid), 32'd0);
    checkOutput("rd31_rst_rdata",  obsDrdata, 32'd0);
    applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    checkOutput("rd31_after_rvalid", 32'(obsDrvalid), 32'd0);

    // Randomized traffic, alternating held-lock blocks and free-running blocks.
    for (int blk = 0; blk < 8; blk++) begin
      holdLock = (blk % 2) == 1;
      for (int i = 0; i < 50; i++) begin
        applyStimulus(!holdLock && ($urandom_range(0, 39) == 0),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      AW'($urandom_range(0, 31)), $urandom,
                      holdLock ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 1) == 1,
                      holdLock ? 1'b1 : ($urandom_range(0, 1) == 1),
                      AW'($urandom_range(0, 31)), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
